// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the SRAM arbiter slice.
//   arb_state_t       : arbiter state (ARB_IDLE = no owner, ARB_ACCESS = owner valid)
//   LOCK_MAX_DEFAULT  : default number of consecutive locked grants before a
//                       forced release when another requester is waiting
//   cnt_width()       : width of a counter that must hold 0 .. max_val-1
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  localparam int LOCK_MAX_DEFAULT = 8;

  function automatic int cnt_width(input int max_val);
    return (max_val > 2) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first set bit of req at or
// after position ptr, wrapping modulo N.
//   req   [N-1:0] : candidate vector
//   ptr   [W-1:0] : starting position (0 .. N-1)
//   idx   [W-1:0] : index of the selected candidate (0 when none)
//   found         : at least one candidate present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [W-1:0]   offset;
  logic [W:0]     sum;

  // Rotate so that position ptr lands on bit 0; the first set bit of the
  // rotated vector is then the round-robin winner's distance from ptr.
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> ptr);
  assign found   = |req_rot;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    offset = '0;
    // Descending scan: the lowest set bit is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = W'(k);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, offset};
  assign idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one single-port synchronous SRAM between N_REQ requesters with
// round-robin arbitration and an optional bounded lock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req/lock/we [N_REQ] : per-requester request, keep-ownership, write enable
//   addr, din           : per-requester address and write data
//   gnt   [N_REQ]       : one-hot, access performed this cycle
//   rvalid[N_REQ]       : one-hot, read data valid this cycle
//   rdata               : read data broadcast (SRAM output passed through)
//   mem_cs/mem_we/mem_addr/mem_din : SRAM command port
//   mem_dout            : SRAM registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module sram_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 3,
  parameter int LOCK_MAX   = LOCK_MAX_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req,
  input  logic [N_REQ-1:0]                    lock,
  input  logic [N_REQ-1:0]                    we,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    din,
  output logic [N_REQ-1:0]                    gnt,
  output logic [N_REQ-1:0]                    rvalid,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                mem_cs,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_din,
  input  logic [DATA_WIDTH-1:0]               mem_dout
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = cnt_width(LOCK_MAX);
  localparam logic [CW-1:0] CNT_TOP  = CW'(LOCK_MAX - 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

  arb_state_t      state, state_d;
  logic [OW-1:0]   owner, owner_d;
  logic [OW-1:0]   rr_ptr, rr_ptr_d;
  logic [CW-1:0]   lock_cnt, lock_cnt_d;

  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;
  logic             owner_lock;
  logic             others_req;
  logic             hold;
  logic [OW-1:0]    next_ptr;

  logic [N_REQ-1:0] pick_req;
  logic [OW-1:0]    pick_ptr;
  logic [OW-1:0]    pick_idx;
  logic             pick_found;

  assign owner_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign owner_req  = |(owner_oh & req);
  assign owner_lock = |(owner_oh & lock);
  assign others_req = |(req & ~owner_oh);
  assign next_ptr   = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // A granted, locked owner keeps the SRAM until its lock budget is spent;
  // once spent it only keeps it while nobody else is waiting.
  assign hold = owner_req && owner_lock && ((lock_cnt != CNT_TOP) || !others_req);

  // Grant is qualified by the live request so a dropped request is never served.
  assign gnt = (state == ARB_ACCESS) ? (owner_oh & req) : '0;

  // Idle: search all requests from rr_ptr. Release: search everyone except the
  // outgoing owner, starting just after it, so the handoff is back-to-back.
  assign pick_req = (state == ARB_IDLE) ? req    : (req & ~owner_oh);
  assign pick_ptr = (state == ARB_IDLE) ? rr_ptr : next_ptr;

  rr_picker #(
    .N (N_REQ),
    .W (OW)
  ) u_rr_picker (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    lock_cnt_d = lock_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_ACCESS;
          owner_d = pick_idx;
        end
      end
      ARB_ACCESS: begin
        if (hold) begin
          // Saturates at CNT_TOP when the owner is alone.
          if (lock_cnt != CNT_TOP) lock_cnt_d = lock_cnt + 1'b1;
        end else begin
          rr_ptr_d   = next_ptr;
          lock_cnt_d = '0;
          if (pick_found) owner_d = pick_idx;
          else            state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
      rvalid   <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      lock_cnt <= lock_cnt_d;
      // SRAM read data appears one cycle after the read command.
      rvalid   <= gnt & ~we;
    end
  end

  // gnt is one-hot, so the loop acts as a simple mux onto the SRAM port.
  always_comb begin
    mem_cs   = |gnt;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mem_we   = we[i];
        mem_addr = addr[i];
        mem_din  = din[i];
      end
    end
  end

  assign rdata = mem_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed scenarios with literal expectations, then randomized traffic. A
// behavioural model (owner / pointer / lock count as plain integers, plus a
// shadow memory) predicts every output each cycle; a simple SRAM model drives
// mem_dout.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int OW = 2;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LM = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req, lock, we;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] din;
  logic [N-1:0]         gnt, rvalid;
  logic [DW-1:0]        rdata;
  logic                 mem_cs, mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_din, mem_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_REQ      (N),
    .LOCK_MAX   (LM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // SRAM model: contents restored to k*17 on reset, 1-cycle read latency.
  logic [DW-1:0] sram [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) sram[k] <= DW'(k * 17);
      mem_dout <= '0;
    end else if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      else        mem_dout <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit            m_busy;
  int            m_owner, m_ptr, m_cnt;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_mem [16];

  function automatic int first_from(input int unsigned v, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (((v >> j) & 1) != 0) return j;
    end
    return 0;
  endfunction

  always @(negedge clk) begin : cmp
    logic [N-1:0]  e_gnt;
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [N-1:0]  nxt_rv;
    logic [DW-1:0] nxt_rd;
    int unsigned   r, others;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_rv = '0; m_rd = '0;
      for (int k = 0; k < 16; k++) m_mem[k] = DW'(k * 17);
      check("rst_gnt",    32'(gnt),    0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_cs",     32'(mem_cs), 0);
      check("rst_we",     32'(mem_we), 0);
    end else begin
      r = 32'(req);
      e_gnt = '0; e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
      if (m_busy && ((r >> m_owner) & 1) != 0) begin
        e_gnt  = N'(1 << m_owner);
        e_cs   = 1'b1;
        e_we   = we[OW'(m_owner)];
        e_addr = addr[OW'(m_owner)];
        e_din  = din[OW'(m_owner)];
      end
      check("gnt",      32'(gnt),      32'(e_gnt));
      check("mem_cs",   32'(mem_cs),   32'(e_cs));
      check("mem_we",   32'(mem_we),   32'(e_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_din",  32'(mem_din),  32'(e_din));
      check("rvalid",   32'(rvalid),   32'(m_rv));
      if (m_rv != '0) check("rdata", 32'(rdata), 32'(m_rd));

      nxt_rv = '0;
      nxt_rd = m_rd;
      if (e_gnt != '0) begin
        if (e_we) m_mem[e_addr] = e_din;
        else begin
          nxt_rv = e_gnt;
          nxt_rd = m_mem[e_addr];
        end
      end

      if (!m_busy) begin
        if (r != 0) begin
          m_owner = first_from(r, m_ptr);
          m_busy  = 1;
        end
      end else begin
        others = r & ~(32'd1 << m_owner);
        if ((e_gnt != '0) && lock[OW'(m_owner)] && (m_cnt < LM - 1 || others == 0)) begin
          if (m_cnt < LM - 1) m_cnt++;
        end else begin
          m_ptr = (m_owner + 1) % N;
          m_cnt = 0;
          if (others != 0) m_owner = first_from(others, m_ptr);
          else             m_busy  = 0;
        end
      end
      m_rv = nxt_rv;
      m_rd = nxt_rd;
    end
  end

  logic [N-1:0] seen_gnt;
  always @(negedge clk) seen_gnt <= gnt;

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req = '0; lock = '0; we = '0; addr = '0; din = '0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rot [4];
    idle_inputs();
    rst_n = 1'b0;
    do_reset();

    // Single read: grant one cycle after the request, data one cycle later.
    req = 3'b001; addr[0] = 4'h5;
    #2 check("rd_req_cycle_gnt", 32'(gnt), 0);
    step(); #2;
    check("rd_gnt",  32'(gnt),      32'h1);
    check("rd_addr", 32'(mem_addr), 32'h5);
    check("rd_cs",   32'(mem_cs),   32'h1);
    step();
    req = '0;
    #2;
    check("rd_rvalid", 32'(rvalid), 32'h1);
    check("rd_rdata",  32'(rdata),  32'h55);

    // Three open requests rotate without a gap.
    do_reset();
    req = 3'b111; addr[0] = 4'h1; addr[1] = 4'h2; addr[2] = 4'h3;
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step(); #2;
      check("rot_gnt", 32'(gnt),    32'(rot[k]));
      check("rot_cs",  32'(mem_cs), 32'h1);
    end

    // Locked owner with a competitor: exactly LM grants, then handoff.
    do_reset();
    req = 3'b011; lock = 3'b001;
    for (int k = 0; k < LM; k++) begin
      step(); #2;
      check("lock_hold_gnt", 32'(gnt), 32'h1);
    end
    step(); #2;
    check("lock_release_gnt", 32'(gnt), 32'h2);

    // Locked owner alone keeps the SRAM; the count saturates.
    do_reset();
    req = 3'b001; lock = 3'b001;
    for (int k = 0; k < 20; k++) begin
      step(); #2;
      check("sat_gnt", 32'(gnt), 32'h1);
    end
    check("sat_lock_cnt", 32'(dut.lock_cnt), 32'd7);

    // Single write by requester 2.
    do_reset();
    req = 3'b100; we = 3'b100; addr[2] = 4'hF; din[2] = 8'hA5;
    step(); #2;
    check("wr_gnt",  32'(gnt),      32'h4);
    check("wr_we",   32'(mem_we),   32'h1);
    check("wr_addr", 32'(mem_addr), 32'hF);
    check("wr_din",  32'(mem_din),  32'hA5);
    step();
    req = '0; we = '0;
    #2;
    check("wr_after_cs", 32'(mem_cs), 0);
    check("wr_rvalid",   32'(rvalid), 0);
    step(); #2;
    check("wr_rvalid_late", 32'(rvalid), 0);

    // Reset pulse during a locked read.
    do_reset();
    req = 3'b101; lock = 3'b001; addr[0] = 4'h3; addr[2] = 4'h7;
    step(); #2;
    check("ar_pre_gnt", 32'(gnt), 32'h1);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("ar_gnt",    32'(gnt),      0);
    check("ar_rvalid", 32'(rvalid),   0);
    check("ar_cs",     32'(mem_cs),   0);
    check("ar_we",     32'(mem_we),   0);
    check("ar_addr",   32'(mem_addr), 0);
    req = 3'b110; lock = '0;
    step();
    rst_n = 1'b1;
    #2;
    check("ar_idle_gnt",    32'(gnt),    0);
    check("ar_idle_rvalid", 32'(rvalid), 0);
    step(); #2;
    check("ar_next_gnt",    32'(gnt),    32'h2);
    check("ar_next_rvalid", 32'(rvalid), 0);

    // Randomized traffic, requests held until granted.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        logic [OW-1:0] ii;
        ii = OW'(i);
        if (req[ii] && !seen_gnt[ii]) begin
          // waiting: hold everything stable
        end else if (req[ii] && seen_gnt[ii] && lock[ii] && $urandom_range(0, 99) < 85) begin
          we[ii]   = 1'($urandom_range(0, 1));
          addr[ii] = AW'($urandom_range(0, 15));
          din[ii]  = DW'($urandom);
        end else if ($urandom_range(0, 99) < 45) begin
          req[ii]  = 1'b1;
          we[ii]   = 1'($urandom_range(0, 1));
          addr[ii] = AW'($urandom_range(0, 15));
          din[ii]  = DW'($urandom);
          lock[ii] = ($urandom_range(0, 99) < 35);
        end else begin
          req[ii]  = 1'b0;
          lock[ii] = 1'b0;
        end
      end
    end
    idle_inputs();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the SRAM data width.
REQ-003 SHALL have parameter N_REQ, default 3, the number of requesters (range 2..8).
REQ-004 SHALL have parameter LOCK_MAX, default 8, the maximum consecutive locked grants before a forced release.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 req  input  N_REQ  access request, one bit per requester.
REQ-008 lock  input  N_REQ  requester asks to keep ownership after the current access.
REQ-009 we  input  N_REQ  write enable per requester (1 = write, 0 = read).
REQ-010 addr  input  N_REQ x ADDR_WIDTH  per-requester address.
REQ-011 din  input  N_REQ x DATA_WIDTH  per-requester write data.
REQ-012 gnt  output  N_REQ  one-hot; access performed this cycle for that requester.
REQ-013 rvalid  output  N_REQ  one-hot; read data valid for that requester.
REQ-014 rdata  output  DATA_WIDTH  read data, broadcast to all requesters.
REQ-015 mem_cs, mem_we  output  1 each  SRAM chip select and write enable.
REQ-016 mem_addr  output  ADDR_WIDTH  SRAM address.
REQ-017 mem_din  output  DATA_WIDTH  SRAM write data.
REQ-018 mem_dout  input  DATA_WIDTH  SRAM registered read data (1-cycle latency).

Function
REQ-019 SHALL implement the states ARB_IDLE (no owner) and ARB_ACCESS (registered owner index valid).
REQ-020 In ARB_IDLE with req != 0, SHALL register owner = first set req bit at or after rr_ptr (wrapping modulo N_REQ) and enter ARB_ACCESS; with req == 0, SHALL stay in ARB_IDLE.
REQ-021 gnt[i] SHALL be 1 only when state == ARB_ACCESS, owner == i and req[i] == 1; at most one bit is ever set.
REQ-022 When gnt[i] = 1, SHALL drive mem_cs = 1, mem_we = we[i], mem_addr = addr[i], mem_din = din[i]; otherwise SHALL drive mem_cs = 0, mem_we = 0, and mem_addr/mem_din = 0.
REQ-023 SHALL assert rvalid[i] exactly one cycle after a cycle with gnt[i] = 1 and we[i] = 0; rdata = mem_dout.
REQ-024 Latency: a request raised in ARB_IDLE at cycle t SHALL get gnt at t+1; for a read, rvalid follows at t+2.
REQ-025 In ARB_ACCESS with gnt[owner] = 1, lock[owner] = 1 and lock_cnt < LOCK_MAX-1, SHALL keep the owner and increment lock_cnt.
REQ-026 When lock_cnt reaches LOCK_MAX-1 and another requester has req = 1, SHALL force a release; with no other request, the owner SHALL keep ownership and lock_cnt SHALL saturate.
REQ-027 On release, SHALL set rr_ptr = owner+1 modulo N_REQ, clear lock_cnt, and pick the next owner from req (excluding the old owner's current cycle) in the same edge; with no candidate, SHALL go to ARB_IDLE.
REQ-028 If the owner drops req, or gnt[owner] = 1 with lock[owner] = 0, SHALL release on that edge (back-to-back handoff, no idle cycle).
REQ-029 A request SHALL be held stable (req/we/addr/din) until its gnt is seen; the arbiter SHALL never grant a requester whose req is 0.
REQ-030 Simultaneous requests SHALL be served in round-robin order starting at rr_ptr.

Reset
REQ-031 On rst_n = 0, SHALL immediately go to state = ARB_IDLE, owner = 0, rr_ptr = 0, lock_cnt = 0, gnt = 0, rvalid = 0, mem_cs = 0, mem_we = 0.
REQ-032 A reset asserted mid-access SHALL drop any pending rvalid; after release, SHALL start arbitration on the first edge with rst_n = 1.

Structure
REQ-033 The arb_state_t enum (ARB_IDLE, ARB_ACCESS) SHALL live in the shared package arb_pkg, along with the default LOCK_MAX.
REQ-034 Round-robin selection SHALL be a separate combinational sub-module, rr_picker (inputs req and ptr; outputs idx and found).

Verification
REQ-035 Reset, then req = 3'b001, we = 0, addr = 4'h5 at cycle t -> gnt = 001 at t+1, mem_addr = 5, rvalid = 001 at t+2, rdata = mem_dout.
REQ-036 req = 3'b111 held, lock = 0 -> grants rotate 001, 010, 100, 001 on consecutive cycles, mem_cs continuously 1.
REQ-037 req = 3'b011, lock[0] = 1, LOCK_MAX = 8 -> requester 0 holds gnt for exactly 8 cycles, then gnt = 010.
REQ-038 req = 3'b001, lock[0] = 1 alone for 20 cycles -> gnt stays 001 for all 20 cycles, lock_cnt saturates at 7.
REQ-039 Write req[2] = 1, we = 1, addr = 4'hF, din = 8'hA5 -> mem_we = 1, mem_addr = F, mem_din = A5 for one cycle, no rvalid.
REQ-040 rst_n pulsed low during a locked read -> all outputs 0 asynchronously, no rvalid afterwards, next grant goes to the lowest pending index.
